// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch path: widths, fetch states and the
// default table of opcodes that carry an immediate byte.
package fetch_pkg;

    localparam int unsigned OPCODE_W = 4;
    localparam int unsigned INSTR_W  = 8;

    // Bit i set: opcode i is followed by an 8-bit immediate (opcodes 3 and 10).
    localparam logic [15:0] DEFAULT_TWO_BYTE_MASK = 16'h0408;

    typedef enum logic {
        S_OP,
        S_IMM
    } fetch_state_e;

    function automatic logic has_immediate(input logic [15:0]         mask,
                                           input logic [OPCODE_W-1:0] op);
        return mask[op];
    endfunction

endpackage

// File: rtl/pc_counter.sv
// Program counter: load on redirect, otherwise optional increment, wrapping modulo 2^ADDR_W.
module pc_counter #(
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_value,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= ADDR_W'(RESET_PC);
        end else if (load) begin
            pc <= load_value;
        end else if (inc) begin
            pc <= pc + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetches bytes from a combinational instruction memory, assembles one- or two-byte
// instructions and presents them to the consumer over a valid/ready handshake.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W        = 5,
    parameter int unsigned RESET_PC      = 0,
    parameter logic [15:0] TWO_BYTE_MASK = DEFAULT_TWO_BYTE_MASK
) (
    input  logic                clk,
    input  logic                reset,
    output logic [ADDR_W-1:0]   address,
    input  logic [INSTR_W-1:0]  data,
    input  logic                halt,
    input  logic                jump_en,
    input  logic [ADDR_W-1:0]   jump_target,
    output logic                instr_valid,
    input  logic                instr_ready,
    output logic [OPCODE_W-1:0] opcode,
    output logic [3:0]          operand,
    output logic [7:0]          imm,
    output logic                has_imm,
    output logic [ADDR_W-1:0]   instr_pc
);

    fetch_state_e      state;
    logic [ADDR_W-1:0] pc;
    logic              slot_free;
    logic              fetch_op;
    logic              fetch_imm;
    logic [OPCODE_W-1:0] data_op;

    assign data_op   = data[INSTR_W-1:INSTR_W-OPCODE_W];
    assign slot_free = !instr_valid || instr_ready;
    assign fetch_op  = (state == S_OP) && !halt && slot_free;
    assign fetch_imm = (state == S_IMM) && !halt;
    assign address   = pc;

    // Load takes priority inside the counter, so a jump overrides any increment.
    pc_counter #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_counter (
        .clk        (clk),
        .reset      (reset),
        .load       (jump_en),
        .load_value (jump_target),
        .inc        (fetch_op || fetch_imm),
        .pc         (pc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_OP;
            instr_valid <= 1'b0;
            opcode      <= '0;
            operand     <= '0;
            imm         <= '0;
            has_imm     <= 1'b0;
            instr_pc    <= '0;
        end else if (jump_en) begin
            // Discards any half-built instruction; a same-cycle handshake still completes.
            state       <= S_OP;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                S_OP: begin
                    if (fetch_op) begin
                        opcode   <= data_op;
                        operand  <= data[3:0];
                        instr_pc <= pc;
                        if (has_immediate(TWO_BYTE_MASK, data_op)) begin
                            state       <= S_IMM;
                            instr_valid <= 1'b0;
                        end else begin
                            has_imm     <= 1'b0;
                            imm         <= '0;
                            instr_valid <= 1'b1;
                        end
                    end else if (instr_valid && instr_ready) begin
                        instr_valid <= 1'b0;
                    end
                end
                S_IMM: begin
                    if (fetch_imm) begin
                        imm         <= data;
                        has_imm     <= 1'b1;
                        instr_valid <= 1'b1;
                        state       <= S_OP;
                    end
                end
                default: state <= S_OP;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: a ROM walk predicts the instruction stream,
// a negedge monitor pops and compares every handshake, and per-scenario tasks check timing.
module tb_instruction_fetch_unit;

    typedef struct packed {
        logic [3:0] opcode;
        logic [3:0] operand;
        logic [7:0] imm;
        logic       has_imm;
        logic [4:0] pc;
    } instr_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] address;
    logic [7:0] data;
    logic       halt = 1'b0;
    logic       jump_en = 1'b0;
    logic [4:0] jump_target = '0;
    logic       instr_valid;
    logic       instr_ready = 1'b1;
    logic [3:0] opcode;
    logic [3:0] operand;
    logic [7:0] imm;
    logic       has_imm;
    logic [4:0] instr_pc;

    logic [7:0]  rom [32];
    logic [15:0] two_byte = 16'h0408;
    instr_t      exp_q [$];
    instr_t      mon_got;
    instr_t      mon_want;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    assign data = rom[address];

    instruction_fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .address     (address),
        .data        (data),
        .halt        (halt),
        .jump_en     (jump_en),
        .jump_target (jump_target),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .opcode      (opcode),
        .operand     (operand),
        .imm         (imm),
        .has_imm     (has_imm),
        .instr_pc    (instr_pc)
    );

    // Walk the ROM from start and queue the next n instructions a correct fetcher would emit.
    task automatic push_stream(input logic [4:0] start, input int n);
        logic [4:0] p;
        logic [4:0] p1;
        instr_t     e;
        p = start;
        for (int i = 0; i < n; i++) begin
            p1        = p + 5'd1;
            e.opcode  = rom[p][7:4];
            e.operand = rom[p][3:0];
            e.pc      = p;
            if (two_byte[rom[p][7:4]]) begin
                e.imm     = rom[p1];
                e.has_imm = 1'b1;
                p         = p + 5'd2;
            end else begin
                e.imm     = 8'h00;
                e.has_imm = 1'b0;
                p         = p1;
            end
            exp_q.push_back(e);
        end
    endtask

    // Inputs change at posedge+1, so at negedge valid&ready is exactly the upcoming handshake.
    always @(negedge clk) begin
        if (!reset && instr_valid && instr_ready) begin
            mon_got = {opcode, operand, imm, has_imm, instr_pc};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_underflow got=%h expected none", mon_got);
            end else begin
                mon_want = exp_q.pop_front();
                if (mon_got !== mon_want) begin
                    errors++;
                    $display("FAIL scoreboard got op=%h opd=%h imm=%h hi=%b pc=%0d want op=%h opd=%h imm=%h hi=%b pc=%0d",
                             mon_got.opcode, mon_got.operand, mon_got.imm, mon_got.has_imm,
                             mon_got.pc, mon_want.opcode, mon_want.operand, mon_want.imm,
                             mon_want.has_imm, mon_want.pc);
                end
            end
        end
    end

    task automatic wait_valid(input string name, output int n);
        n = 0;
        while (!instr_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n != 2) begin
            errors++;
            $display("FAIL %s_latency got=%0d cycles expected=2", name, n);
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (instr_valid !== 1'b0 || address !== 5'd0) begin
            errors++;
            $display("FAIL reset_valid_addr got valid=%b addr=%0d expected 0/0", instr_valid, address);
        end
        checks++;
        if ({opcode, operand, imm, has_imm, instr_pc} !== 22'd0) begin
            errors++;
            $display("FAIL reset_outputs got op=%h opd=%h imm=%h hi=%b pc=%0d expected all 0",
                     opcode, operand, imm, has_imm, instr_pc);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        push_stream(5'd0, 40);
    endtask

    task automatic test_first_fetch();
        int n;
        wait_valid("first", n);
        checks++;
        if ({opcode, operand, imm, has_imm, instr_pc} !== {4'h3, 4'h9, 8'h00, 1'b1, 5'd0}) begin
            errors++;
            $display("FAIL first_instr got op=%h opd=%h imm=%h hi=%b pc=%0d expected 3/9/00/1/0",
                     opcode, operand, imm, has_imm, instr_pc);
        end
    endtask

    task automatic test_sequence();
        int n = 0;
        @(negedge clk);
        while (!(instr_valid && instr_pc == 5'd4) && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if ({opcode, operand, imm, has_imm} !== {4'hA, 4'h6, 8'hEF, 1'b1}) begin
            errors++;
            $display("FAIL seq_pc4 got op=%h opd=%h imm=%h hi=%b pc=%0d expected A/6/EF/1/4",
                     opcode, operand, imm, has_imm, instr_pc);
        end
        @(negedge clk);
        checks++;
        if (!instr_valid || instr_pc !== 5'd6 || opcode !== 4'h8 || has_imm !== 1'b0) begin
            errors++;
            $display("FAIL seq_pc6 got valid=%b pc=%0d op=%h hi=%b expected 1/6/8/0",
                     instr_valid, instr_pc, opcode, has_imm);
        end
        @(posedge clk);
        #1 instr_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (!instr_valid || instr_pc !== 5'd7 || opcode !== 4'h1 || operand !== 4'h5
                || address !== 5'd8) begin
                errors++;
                $display("FAIL bp_hold got valid=%b pc=%0d op=%h opd=%h addr=%0d expected 1/7/1/5/8",
                         instr_valid, instr_pc, opcode, operand, address);
            end
        end
        @(posedge clk);
        #1 instr_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (!instr_valid || instr_pc !== 5'd8) begin
            errors++;
            $display("FAIL bp_release got valid=%b pc=%0d expected 1/8", instr_valid, instr_pc);
        end
    endtask

    task automatic test_halt();
        logic [4:0] addr0;
        @(posedge clk);
        #1 halt = 1'b1;
        @(negedge clk);
        addr0 = address;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (address !== addr0 || instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL halt_hold got addr=%0d valid=%b expected addr=%0d valid=0",
                         address, instr_valid, addr0);
            end
        end
        @(posedge clk);
        #1 halt = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_jump();
        int n;
        @(posedge clk);
        #1 reset = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (address !== 5'd1 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL jump_pre got addr=%0d valid=%b expected 1/0", address, instr_valid);
        end
        jump_en     = 1'b1;
        jump_target = 5'd2;
        @(posedge clk);
        #1 jump_en = 1'b0;
        exp_q.delete();
        push_stream(5'd2, 40);
        checks++;
        if (address !== 5'd2 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL jump_redirect got addr=%0d valid=%b expected 2/0", address, instr_valid);
        end
        wait_valid("jump", n);
        checks++;
        if ({opcode, operand, imm, has_imm, instr_pc} !== {4'h3, 4'h2, 8'h01, 1'b1, 5'd2}) begin
            errors++;
            $display("FAIL jump_instr got op=%h opd=%h imm=%h hi=%b pc=%0d expected 3/2/01/1/2",
                     opcode, operand, imm, has_imm, instr_pc);
        end
    endtask

    task automatic test_wrap();
        int n;
        rom[31] = 8'h3F;
        @(posedge clk);
        #1 jump_en = 1'b1;
        jump_target = 5'd31;
        @(posedge clk);
        #1 jump_en = 1'b0;
        exp_q.delete();
        push_stream(5'd31, 40);
        wait_valid("wrap", n);
        checks++;
        if ({opcode, operand, imm, has_imm, instr_pc} !== {4'h3, 4'hF, 8'h39, 1'b1, 5'd31}
            || address !== 5'd1) begin
            errors++;
            $display("FAIL wrap_instr got op=%h opd=%h imm=%h hi=%b pc=%0d addr=%0d expected 3/F/39/1/31 addr 1",
                     opcode, operand, imm, has_imm, instr_pc, address);
        end
    endtask

    task automatic test_async_reset();
        int n;
        @(posedge clk);
        #1 jump_en = 1'b1;
        jump_target = 5'd4;
        @(posedge clk);
        #1 jump_en = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #2;
        checks++;
        if (address !== 5'd5 || opcode !== 4'hA || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL areset_pre got addr=%0d op=%h valid=%b expected 5/A/0",
                     address, opcode, instr_valid);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (instr_valid !== 1'b0 || address !== 5'd0 || opcode !== 4'h0 || instr_pc !== 5'd0) begin
            errors++;
            $display("FAIL areset_now got valid=%b addr=%0d op=%h pc=%0d expected 0/0/0/0",
                     instr_valid, address, opcode, instr_pc);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        push_stream(5'd0, 40);
        wait_valid("areset_restart", n);
        repeat (6) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = 8'h00;
        rom[0]  = 8'h39; rom[1]  = 8'h00; rom[2]  = 8'h32; rom[3]  = 8'h01;
        rom[4]  = 8'hA6; rom[5]  = 8'hEF; rom[6]  = 8'h85; rom[7]  = 8'h15;
        rom[8]  = 8'h27; rom[9]  = 8'h40; rom[10] = 8'h3C; rom[11] = 8'h55;
        rom[12] = 8'h61; rom[13] = 8'h72; rom[14] = 8'hA0; rom[15] = 8'h7E;
        rom[16] = 8'h94;
        test_reset();
        test_first_fetch();
        test_sequence();
        test_backpressure();
        test_halt();
        test_jump();
        test_wrap();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog_timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
